// File: rtl/sdram_pkg.sv
// Shared SDRAM constants: command encodings, refresh FSM states and default timings.
// Used by the refresh block and the init sequencer alike.
package sdram_pkg;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;

  localparam int DEF_REF_PERIOD = 1500;
  localparam int DEF_TRP_CYC    = 2;
  localparam int DEF_TRC_CYC    = 7;

  // Address bit that selects "all banks" on PRECHARGE.
  localparam int A10_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECH,
    ST_WAIT_TRP,
    ST_AREF1,
    ST_WAIT_TRC1,
    ST_AREF2,
    ST_WAIT_TRC2
  } aref_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_aref_timer.sv
// Free-running refresh interval timer; raises the refresh request and flags
// an overflow when an interval elapses with a request still pending.
module sdram_aref_timer
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic init_done,
  input  logic accept,
  output logic req,
  output logic ovf
);

  localparam int TMR_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REF_PERIOD - 1);

  logic [TMR_W-1:0] cnt;
  logic             terminal;

  assign terminal = init_done && (cnt == TMR_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      req <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (!init_done || terminal) cnt <= '0;
      else                        cnt <= cnt + 1'b1;

      // A grant on the same edge as a terminal count retires the old request.
      if (!init_done) begin
        req <= 1'b0;
      end else if (terminal) begin
        req <= 1'b1;
        if (req && !accept) ovf <= 1'b1;
      end else if (accept) begin
        req <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh controller: PRECHARGE ALL followed by two AUTO REFRESH
// commands, issued once per refresh interval after the arbiter grants the bus.
module sdram_aref
  import sdram_pkg::*;
#(
  parameter int SDRAM_BANK_WIDTH = 2,
  parameter int SDRAM_ADDR_WIDTH = 12,
  parameter int REF_PERIOD       = DEF_REF_PERIOD,
  parameter int TRP_CYC          = DEF_TRP_CYC,
  parameter int TRC_CYC          = DEF_TRC_CYC
) (
  input  logic                        Sys_clk,
  input  logic                        Rst,
  input  logic                        INIT_DONE,
  input  logic                        REF_EN,
  output logic                        REF_REQ,
  output logic [3:0]                  COMMAND_REF,
  output logic [SDRAM_ADDR_WIDTH-1:0] REF_A_ADDR,
  output logic [SDRAM_BANK_WIDTH-1:0] REF_BANK_ADDR,
  output logic                        REF_DONE,
  output logic                        REF_OVF
);

  localparam int WAIT_MAX = max_int(TRP_CYC, TRC_CYC);
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] TRP_LOAD = WAIT_W'(TRP_CYC - 1);
  localparam logic [WAIT_W-1:0] TRC_LOAD = WAIT_W'(TRC_CYC - 1);
  localparam logic [SDRAM_ADDR_WIDTH-1:0] ADDR_ALL_BANKS = SDRAM_ADDR_WIDTH'(1) << A10_BIT;

  aref_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;

  assign accept = REF_EN && REF_REQ && (state == ST_IDLE);

  sdram_aref_timer #(
    .REF_PERIOD(REF_PERIOD)
  ) u_timer (
    .clk      (Sys_clk),
    .rst      (Rst),
    .init_done(INIT_DONE),
    .accept   (accept),
    .req      (REF_REQ),
    .ovf      (REF_OVF)
  );

  // Outputs are registered against the state being entered, so COMMAND_REF
  // lines up with the state it belongs to.
  always_ff @(posedge Sys_clk or posedge Rst) begin
    if (Rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      COMMAND_REF   <= CMD_NOP;
      REF_A_ADDR    <= '0;
      REF_BANK_ADDR <= '0;
      REF_DONE      <= 1'b0;
    end else begin
      // NOTE: defaults first, so any branch that leaves an output alone drives NOP/zero.
      COMMAND_REF   <= CMD_NOP;
      REF_A_ADDR    <= '0;
      REF_BANK_ADDR <= '0;
      REF_DONE      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_PRECH;
            wait_cnt    <= '0;
            COMMAND_REF <= CMD_PRECHARGE;
            REF_A_ADDR  <= ADDR_ALL_BANKS;
          end
        end
        ST_PRECH: begin
          state    <= ST_WAIT_TRP;
          wait_cnt <= TRP_LOAD;
        end
        ST_WAIT_TRP: begin
          if (wait_cnt == '0) begin
            state       <= ST_AREF1;
            wait_cnt    <= '0;
            COMMAND_REF <= CMD_AREF;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_AREF1: begin
          state    <= ST_WAIT_TRC1;
          wait_cnt <= TRC_LOAD;
        end
        ST_WAIT_TRC1: begin
          if (wait_cnt == '0) begin
            state       <= ST_AREF2;
            wait_cnt    <= '0;
            COMMAND_REF <= CMD_AREF;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_AREF2: begin
          state    <= ST_WAIT_TRC2;
          wait_cnt <= TRC_LOAD;
          REF_DONE <= (TRC_CYC == 1);
        end
        ST_WAIT_TRC2: begin
          if (wait_cnt == '0) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
            // Pulse lands in the final wait cycle.
            REF_DONE <= (wait_cnt == WAIT_W'(1));
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_aref.sv
// Directed bench for sdram_aref: expected command streams are queued when a
// grant is driven and popped cycle by cycle as the DUT issues commands.
module tb_sdram_aref;

  localparam int PERIOD = 20;
  localparam int TRP    = 2;
  localparam int TRC    = 7;

  localparam logic [3:0]  NOP  = 4'b0111;
  localparam logic [3:0]  PRE  = 4'b0010;
  localparam logic [3:0]  AREF = 4'b0001;
  localparam logic [11:0] A10  = 12'h400;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        ref_en;
  logic        ref_req;
  logic [3:0]  command_ref;
  logic [11:0] ref_a_addr;
  logic [1:0]  ref_bank_addr;
  logic        ref_done;
  logic        ref_ovf;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  sdram_aref #(
    .SDRAM_BANK_WIDTH(2),
    .SDRAM_ADDR_WIDTH(12),
    .REF_PERIOD      (PERIOD),
    .TRP_CYC         (TRP),
    .TRC_CYC         (TRC)
  ) dut (
    .Sys_clk      (clk),
    .Rst          (rst),
    .INIT_DONE    (init_done),
    .REF_EN       (ref_en),
    .REF_REQ      (ref_req),
    .COMMAND_REF  (command_ref),
    .REF_A_ADDR   (ref_a_addr),
    .REF_BANK_ADDR(ref_bank_addr),
    .REF_DONE     (ref_done),
    .REF_OVF      (ref_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd"},  command_ref,   NOP);
    check({tag, "_addr"}, ref_a_addr,    0);
    check({tag, "_bank"}, ref_bank_addr, 0);
    check({tag, "_req"},  ref_req,       0);
    check({tag, "_done"}, ref_done,      0);
    check({tag, "_ovf"},  ref_ovf,       0);
  endtask

  // Expected outputs for the 19 cycles following an accepted grant.
  task automatic push_seq();
    sb.push_back('{PRE, A10, 1'b0});
    for (int i = 0; i < TRP; i++) sb.push_back('{NOP, 12'h000, 1'b0});
    sb.push_back('{AREF, 12'h000, 1'b0});
    for (int i = 0; i < TRC; i++) sb.push_back('{NOP, 12'h000, 1'b0});
    sb.push_back('{AREF, 12'h000, 1'b0});
    for (int i = 0; i < TRC; i++) sb.push_back('{NOP, 12'h000, (i == TRC - 1)});
  endtask

  task automatic step_check(input string tag);
    exp_t e;
    tick();
    check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_cmd"},  command_ref,   e.cmd);
      check({tag, "_addr"}, ref_a_addr,    e.addr);
      check({tag, "_bank"}, ref_bank_addr, 0);
      check({tag, "_done"}, ref_done,      e.done);
    end
  endtask

  // Request must appear after exactly PERIOD edges of INIT_DONE high.
  task automatic wait_req(input string tag);
    for (int i = 1; i <= PERIOD; i++) begin
      tick();
      check({tag, "_req_timing"}, ref_req, (i == PERIOD));
      check({tag, "_idle_cmd"}, command_ref, NOP);
    end
  endtask

  initial begin
    rst       = 1'b1;
    init_done = 1'b0;
    ref_en    = 1'b0;
    #12;
    check_reset("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    // Timer held while the device is not initialised.
    repeat (5) begin
      tick();
      check("no_init_req", ref_req, 0);
      check("no_init_cmd", command_ref, NOP);
    end

    // First request, then overflow when a second interval elapses ungranted.
    init_done = 1'b1;
    wait_req("first_req");
    for (int i = PERIOD + 1; i <= 2 * PERIOD; i++) begin
      tick();
      check("req_held", ref_req, 1);
      check("ovf_timing", ref_ovf, (i == 2 * PERIOD));
    end

    // Asynchronous reset clears the sticky overflow.
    rst = 1'b1;
    #1;
    check_reset("reset_clears_ovf");
    @(negedge clk);
    rst = 1'b0;

    // Stray grant while no request is pending is ignored.
    for (int i = 1; i <= PERIOD; i++) begin
      if (i == 5) ref_en = 1'b1;
      if (i == 6) ref_en = 1'b0;
      tick();
      check("stray_grant_req", ref_req, (i == PERIOD));
      check("stray_grant_cmd", command_ref, NOP);
    end

    // Single grant one cycle after the request rises; stray grant mid-sequence.
    ref_en = 1'b1;
    push_seq();
    for (int k = 1; k <= 19; k++) begin
      step_check("seq_single");
      check("seq_single_req", ref_req, 0);
      if (k == 1) ref_en = 1'b0;
      if (k == 8) ref_en = 1'b1;
      if (k == 9) ref_en = 1'b0;
    end
    tick();
    check("after_seq_req", ref_req, 1);
    check("after_seq_cmd", command_ref, NOP);
    check("after_seq_ovf", ref_ovf, 0);

    // Grant held high: one sequence per interval, no overflow.
    ref_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      push_seq();
      sb.push_back('{NOP, 12'h000, 1'b0});
      for (int k = 0; k < PERIOD; k++) step_check("seq_cont");
      check("seq_cont_ovf", ref_ovf, 0);
    end
    check("seq_cont_req", ref_req, 1);

    // Reset in the cycle after AREF1 aborts the sequence.
    push_seq();
    for (int k = 1; k <= 5; k++) begin
      step_check("seq_abort");
      if (k == 1) ref_en = 1'b0;
    end
    sb.delete();
    rst = 1'b1;
    #1;
    check_reset("abort_reset_now");
    tick();
    check_reset("abort_reset_next");
    rst = 1'b0;
    wait_req("req_after_abort");

    // INIT_DONE dropped in WAIT_TRC1: sequence still completes, no new request.
    ref_en = 1'b1;
    push_seq();
    for (int k = 1; k <= 19; k++) begin
      step_check("seq_init_drop");
      check("seq_init_drop_req", ref_req, 0);
      if (k == 1) ref_en = 1'b0;
      if (k == 6) init_done = 1'b0;
    end
    repeat (10) begin
      tick();
      check("init_low_req", ref_req, 0);
      check("init_low_cmd", command_ref, NOP);
      check("init_low_done", ref_done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
